mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Two-master arbiter that shares the single-port word memory (2**WIDTH words of 2*WIDTH bits; synchronous write, combinational read) between master 0 (instruction fetch) and master 1 (load/store unit). Fair round-robin selection, optional locked bursts capped at MAX_BURST beats, and a registered read response per master. Sits between the CPU ports and the memory instance; it is the only driver of the memory's we/addr/wdata.

Parameters:
WIDTH, 8, address width; data width is 2*WIDTH
MAX_BURST, 4, maximum consecutive locked beats before forced hand-over (range 1..15)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
m0_req  in  1  master 0 requests a beat this cycle
m0_lock  in  1  master 0 asks to keep ownership after this beat
m0_we  in  1  1 = write, 0 = read
m0_addr  in  WIDTH  word address
m0_wdata  in  2*WIDTH  write data
m0_gnt  out  1  beat accepted this cycle (combinational)
m0_rvalid  out  1  read data valid (registered)
m0_rdata  out  2*WIDTH  read data (registered)
m1_req, m1_lock, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0_*, for master 1
mem_we  out  1  to memory write enable
mem_addr  out  WIDTH  to memory address
mem_wdata  out  2*WIDTH  to memory write data
mem_rdata  in  2*WIDTH  from memory combinational read data

Behaviour:
- Beat = cycle with mN_req && mN_gnt. At most one gnt high per cycle. gnt never high without req.
- Mux: granted master's we/addr/wdata drive mem_*. No grant: mem_we=0, mem_addr=0, mem_wdata=0.
- Write beat: memory updated at that rising edge. Read beat: mem_rdata captured at that edge into mN_rdata; mN_rvalid=1 the following cycle only (one-cycle pulse per read beat). Write beats never raise rvalid. mN_rdata holds its value until the next read beat of that master.
- Read latency 1 cycle from grant; back-to-back read beats give rvalid high every cycle.
- Round-robin pointer `last` (master granted most recently). Both requesting in IDLE: grant !last. Single requester: granted immediately. `last` updates on every beat.
- FSM states: IDLE, OWN0, OWN1.
  - IDLE: arbitrate as above; if the winner's beat has lock=1 -> OWNn, beat counter=1.
  - OWNn: master n has exclusive grant while it holds req; other master gnt=0.
  - OWNn, beat with lock=1: counter++. When counter reaches MAX_BURST and the other master's req=1 -> IDLE with last=n (other master wins the next cycle); otherwise stay and continue.
  - OWNn, counter reaches MAX_BURST with other req=0: stay, counter restarts at 1.
  - OWNn, beat with lock=0 (final beat), or req deasserted -> IDLE.
- MAX_BURST=1: lock has no effect; always return to IDLE after each beat.
- Reset (rst_n low, any time, including mid-burst): state=IDLE, last=1 (master 0 wins first contention), counter=0, m0/m1_rvalid=0, m0/m1_rdata=0; while rst_n low, m0_gnt=m1_gnt=0 and mem_we=0. A read beat whose edge coincides with reset assertion produces no rvalid.
- Address/data checks: no X on mem_addr or mem_we when any gnt is high (concurrent assertion); onehot0 on {m0_gnt, m1_gnt}.

Decomposition:
- Package mem_arb_pkg: typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t; localparam for master count (2) and counter width (4).
- Sub-module rr_pick2: pure combinational 2-way round-robin picker (req[1:0], last -> grant[1:0]); the FSM, counter, muxes and response registers live in mem_arbiter.

Test Plan:
- Reset release, m0 writes 16'hBEEF to 8'h10, then reads 8'h10 -> m0_gnt same cycle, m0_rvalid one cycle later with m0_rdata=16'hBEEF; m1_rvalid stays 0.
- Both request reads every cycle, no lock -> grants alternate m0,m1,m0,m1 starting with m0; each rvalid pulses one cycle after its own grant.
- m1 locked burst of 6 reads (MAX_BURST=4) while m0 requests -> m1 granted 4 consecutive beats, then m0 gets 1 beat, then m1 resumes.
- m0 locked burst of 6 with m1 idle -> 6 consecutive m0 grants, no gap.
- Simultaneous m0 write 16'h1234 @8'h20 and m1 read @8'h20 with last=1 -> m0 wins; m1 granted next cycle and reads 16'h1234.
- rst_n pulsed low in the middle of an m1 locked burst -> gnts and mem_we drop immediately, rvalid=0, state IDLE; first contention after release goes to m0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory arbiter.
//   arb_state_t : ownership FSM encoding (IDLE, OWN0, OWN1)
//   NumMasters  : number of requesting masters
//   CntWidth    : width of the locked-burst beat counter (MAX_BURST <= 15)
package mem_arb_pkg;

  localparam int unsigned NumMasters = 2;
  localparam int unsigned CntWidth   = 4;

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker.
//   req   : request vector, bit n = master n
//   last  : master granted most recently; loses a tie
//   grant : one-hot (or zero) grant vector
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single-port word memory
// (2**WIDTH words of 2*WIDTH bits, synchronous write, combinational read).
// Round-robin between master 0 and master 1, optional locked bursts capped
// at MAX_BURST beats, registered read response per master.
//   clk, rst_n                : clock, asynchronous active-low reset
//   mN_req/lock/we/addr/wdata : master N beat request
//   mN_gnt                    : beat accepted this cycle (combinational)
//   mN_rvalid/rdata           : registered read response, one cycle after grant
//   mem_we/addr/wdata         : memory command, zero when nothing is granted
//   mem_rdata                 : memory combinational read data
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               m0_req,
  input  logic               m0_lock,
  input  logic               m0_we,
  input  logic [WIDTH-1:0]   m0_addr,
  input  logic [2*WIDTH-1:0] m0_wdata,
  output logic               m0_gnt,
  output logic               m0_rvalid,
  output logic [2*WIDTH-1:0] m0_rdata,
  input  logic               m1_req,
  input  logic               m1_lock,
  input  logic               m1_we,
  input  logic [WIDTH-1:0]   m1_addr,
  input  logic [2*WIDTH-1:0] m1_wdata,
  output logic               m1_gnt,
  output logic               m1_rvalid,
  output logic [2*WIDTH-1:0] m1_rdata,
  output logic               mem_we,
  output logic [WIDTH-1:0]   mem_addr,
  output logic [2*WIDTH-1:0] mem_wdata,
  input  logic [2*WIDTH-1:0] mem_rdata
);

  localparam logic [CntWidth-1:0] MaxBurstCnt = CntWidth'(MAX_BURST);
  // With a one-beat cap, locking can never extend ownership.
  localparam bit LockEn = (MAX_BURST > 1);

  arb_state_t            state_q;
  logic                  last_q;
  logic [CntWidth-1:0]   cnt_q;

  logic [NumMasters-1:0] req;
  logic [NumMasters-1:0] pick;
  logic [NumMasters-1:0] gnt;
  logic                  beat;
  logic                  beat_lock;
  logic                  other_req;
  logic [CntWidth-1:0]   cnt_inc;
  logic                  hit_max;

  assign req = {m1_req, m0_req};

  rr_pick2 u_pick (
    .req   (req),
    .last  (last_q),
    .grant (pick)
  );

  // Grant decode; the owner of a locked burst is the only candidate.
  always_comb begin
    gnt = '0;
    if (rst_n) begin
      case (state_q)
        IDLE:    gnt = pick;
        OWN0:    gnt = {1'b0, m0_req};
        OWN1:    gnt = {m1_req, 1'b0};
        default: gnt = '0;
      endcase
    end
  end

  assign m0_gnt    = gnt[0];
  assign m1_gnt    = gnt[1];
  assign beat      = |gnt;
  assign beat_lock = (gnt[0] & m0_lock) | (gnt[1] & m1_lock);
  assign other_req = (state_q == OWN0) ? m1_req : m0_req;
  assign cnt_inc   = cnt_q + 1'b1;
  assign hit_max   = (cnt_inc == MaxBurstCnt);

  // Memory command mux.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt[0]) begin
      mem_we    = m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end else if (gnt[1]) begin
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
  end

  // Ownership FSM, round-robin pointer and burst counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      if (beat) begin
        last_q <= gnt[1];
      end
      case (state_q)
        IDLE: begin
          if (beat && beat_lock && LockEn) begin
            state_q <= gnt[1] ? OWN1 : OWN0;
            cnt_q   <= CntWidth'(1);
          end
        end
        OWN0, OWN1: begin
          if (!beat || !beat_lock) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (hit_max) begin
            // Cap reached: hand over only if the other master is waiting.
            if (other_req) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= CntWidth'(1);
            end
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Registered read responses; write beats never raise rvalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rvalid <= 1'b0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= gnt[0] & ~m0_we;
      m1_rvalid <= gnt[1] & ~m1_we;
      if (gnt[0] && !m0_we) begin
        m0_rdata <= mem_rdata;
      end
      if (gnt[1] && !m1_we) begin
        m1_rdata <= mem_rdata;
      end
    end
  end

`ifndef SYNTHESIS
  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_mem_no_x: assert property (@(posedge clk) disable iff (!rst_n)
                               beat |-> !$isunknown({mem_we, mem_addr}));
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (WIDTH=8, MAX_BURST=4),
// with a behavioural word memory attached to the mem_* port.
module tb_mem_arbiter;

  localparam int unsigned W = 8;

  logic          clk;
  logic          rst_n;
  logic          m0_req, m0_lock, m0_we;
  logic [W-1:0]  m0_addr;
  logic [15:0]   m0_wdata;
  logic          m0_gnt, m0_rvalid;
  logic [15:0]   m0_rdata;
  logic          m1_req, m1_lock, m1_we;
  logic [W-1:0]  m1_addr;
  logic [15:0]   m1_wdata;
  logic          m1_gnt, m1_rvalid;
  logic [15:0]   m1_rdata;
  logic          mem_we;
  logic [W-1:0]  mem_addr;
  logic [15:0]   mem_wdata;
  logic [15:0]   mem_rdata;

  logic [15:0]   mem [256];

  int n_err;
  int n_checks;

  bit t3_m0req [7] = '{0, 1, 1, 1, 1, 1, 1};
  bit t3_lock  [7] = '{1, 1, 1, 1, 1, 1, 0};
  bit t3_g1    [7] = '{1, 1, 1, 1, 0, 1, 1};

  mem_arbiter #(
    .WIDTH     (W),
    .MAX_BURST (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0_req    (m0_req),
    .m0_lock   (m0_lock),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_lock   (m1_lock),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_err = 0;
    n_checks = 0;
    rst_n = 1'b0;
    m0_req = 0; m0_lock = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_lock = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    repeat (2) tick();

    // Reset state, with a pending write that must not be granted.
    m0_req = 1; m0_we = 1; m0_addr = 8'h10; m0_wdata = 16'hBEEF;
    #1;
    chk("rst_m0_gnt", m0_gnt, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_m0_rvalid", m0_rvalid, 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_m1_rvalid", m1_rvalid, 0);

    // m0 write then read of 8'h10.
    rst_n = 1'b1;
    #1;
    chk("wr_m0_gnt", m0_gnt, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 8'h10);
    chk("wr_mem_wdata", mem_wdata, 16'hBEEF);
    tick();
    m0_we = 0;
    #1;
    chk("rd_m0_gnt", m0_gnt, 1);
    chk("wr_no_rvalid", m0_rvalid, 0);
    tick();
    m0_req = 0;
    #1;
    chk("rd_m0_rvalid", m0_rvalid, 1);
    chk("rd_m0_rdata", m0_rdata, 16'hBEEF);
    chk("rd_m1_rvalid", m1_rvalid, 0);
    tick();
    #1;
    chk("rd_rvalid_pulse", m0_rvalid, 0);
    chk("rd_rdata_hold", m0_rdata, 16'hBEEF);

    // m1 alone writes 8'h30, leaving last=1.
    m1_req = 1; m1_we = 1; m1_addr = 8'h30; m1_wdata = 16'hCAFE;
    #1;
    chk("m1_wr_gnt", m1_gnt, 1);
    tick();

    // Both read every cycle: grants alternate starting with m0.
    m0_req = 1; m0_we = 0; m0_addr = 8'h10;
    m1_req = 1; m1_we = 0; m1_addr = 8'h30;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_gnt0", m0_gnt, (i % 2 == 0));
      chk("rr_gnt1", m1_gnt, (i % 2 == 1));
      chk("rr_rvalid0", m0_rvalid, (i % 2 == 1));
      chk("rr_rvalid1", m1_rvalid, (i == 2));
      tick();
    end
    m0_req = 0; m1_req = 0;
    #1;
    chk("rr_last_rvalid1", m1_rvalid, 1);
    chk("rr_rdata1", m1_rdata, 16'hCAFE);
    chk("rr_rdata0", m0_rdata, 16'hBEEF);
    tick();

    // m1 locked burst of 6 with m0 contending: 4 beats, m0 once, m1 resumes.
    m1_req = 1; m1_addr = 8'h30; m0_addr = 8'h10;
    for (int i = 0; i < 7; i++) begin
      m0_req = t3_m0req[i];
      m1_lock = t3_lock[i];
      #1;
      chk("burst_gnt1", m1_gnt, t3_g1[i]);
      chk("burst_gnt0", m0_gnt, !t3_g1[i]);
      chk("burst_rvalid0", m0_rvalid, (i == 5));
      tick();
    end
    m0_req = 0; m1_req = 0; m1_lock = 0;
    tick();

    // m0 locked burst of 6 with m1 idle: no gap at the cap.
    m0_req = 1; m0_we = 0; m0_addr = 8'h10;
    for (int i = 0; i < 6; i++) begin
      m0_lock = (i != 5);
      #1;
      chk("solo_gnt0", m0_gnt, 1);
      chk("solo_rvalid0", m0_rvalid, (i > 0));
      tick();
    end
    m0_req = 0; m0_lock = 0;
    #1;
    chk("solo_last_rvalid0", m0_rvalid, 1);

    // m1 alone reads 8'h30 to set last=1.
    m1_req = 1; m1_we = 0; m1_addr = 8'h30;
    #1;
    chk("pre_m1_gnt", m1_gnt, 1);
    tick();

    // Contention: m0 write 16'h1234 @8'h20 wins, m1 reads it next cycle.
    m0_req = 1; m0_we = 1; m0_addr = 8'h20; m0_wdata = 16'h1234;
    m1_req = 1; m1_we = 0; m1_addr = 8'h20;
    #1;
    chk("wr_rd_gnt0", m0_gnt, 1);
    chk("wr_rd_gnt1", m1_gnt, 0);
    chk("wr_rd_mem_we", mem_we, 1);
    chk("wr_rd_mem_wdata", mem_wdata, 16'h1234);
    chk("pre_m1_rdata", m1_rdata, 16'hCAFE);
    tick();
    m0_req = 0; m0_we = 0;
    #1;
    chk("wr_rd_gnt1_next", m1_gnt, 1);
    chk("wr_rd_mem_we_rd", mem_we, 0);
    chk("wr_rd_mem_addr", mem_addr, 8'h20);
    tick();
    m1_req = 0;
    #1;
    chk("wr_rd_rvalid1", m1_rvalid, 1);
    chk("wr_rd_rdata1", m1_rdata, 16'h1234);
    tick();

    // Reset in the middle of an m1 locked burst.
    m1_req = 1; m1_lock = 1; m1_we = 0; m1_addr = 8'h20;
    #1;
    chk("rb_gnt1_a", m1_gnt, 1);
    tick();
    m0_req = 1; m0_we = 1; m0_addr = 8'h40; m0_wdata = 16'h5555;
    #1;
    chk("rb_gnt1_b", m1_gnt, 1);
    chk("rb_excl_gnt0", m0_gnt, 0);
    chk("rb_rvalid1", m1_rvalid, 1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rb_rst_gnt1", m1_gnt, 0);
    chk("rb_rst_gnt0", m0_gnt, 0);
    chk("rb_rst_mem_we", mem_we, 0);
    chk("rb_rst_rvalid1", m1_rvalid, 0);
    chk("rb_rst_rdata1", m1_rdata, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rb_post_gnt0", m0_gnt, 1);
    chk("rb_post_gnt1", m1_gnt, 0);
    chk("rb_post_rvalid1", m1_rvalid, 0);
    tick();
    m0_req = 0; m0_we = 0; m1_req = 0; m1_lock = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
